motor_cmd_sequencer: RTL and testbench

//   Consumes 3-byte drive commands (cmd1 opcode, cmd2 power, cmd3 duration) from the UART command receiver.

---
 rtl/motor_cmd_sequencer_pkg.sv | 37 +++
 rtl/motor_cmd_sequencer_if.sv | 13 +
 rtl/motor_cmd_sequencer_pwm_gen.sv | 28 ++
 rtl/motor_cmd_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_motor_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_cmd_sequencer_pkg.sv
// Shared types for the motor command sequencer: opcodes, FSM states,
// the queued command record and the wheel-direction decode.
package motor_cmd_pkg;

  typedef enum logic [1:0] {
    OP_STOP = 2'd0,
    OP_FWD  = 2'd1,
    OP_REV  = 2'd2,
    OP_SPIN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DEAD = 2'd3
  } state_e;

  typedef struct packed {
    op_e        op;
    logic       spin_right;
    logic [6:0] power;
    logic [7:0] dur;
  } drive_cmd_t;

  // {dir_l, dir_r}, 1 = forward; STOP keeps both forward
  function automatic logic [1:0] drive_dir(drive_cmd_t c);
    logic [1:0] d;
    case (c.op)
      OP_REV:  d = 2'b00;
      OP_SPIN: d = c.spin_right ? 2'b10 : 2'b01;
      default: d = 2'b11;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// Command handshake from the UART receiver into the sequencer.
interface motor_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd1;
  logic [7:0] cmd2;
  logic [7:0] cmd3;

  modport master (output cmd_valid, output cmd1, output cmd2, output cmd3,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd1, input  cmd2, input  cmd3,
                  output cmd_ready);
endinterface

// File: rtl/motor_cmd_sequencer_pwm_gen.sv
// Shared 7-bit free-running PWM counter with one compare per wheel.
module motor_pwm_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] power_l,
  input  logic [6:0] power_r,
  output logic       pwm_l,
  output logic       pwm_r
);

  logic [6:0] cnt_q, cnt_d;

  // counter wraps naturally every 128 cycles
  always_comb begin
    cnt_d = cnt_q + 7'd1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pwm_l = en && (cnt_q < power_l);
  assign pwm_r = en && (cnt_q < power_r);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: queues 3-byte drive commands and plays them out
// as wheel PWM/direction with a dead-time gap after each one.
// Optional build macro MOTOR_RAMP_EN: effective power ramps up by one per
// duration tick until it reaches the commanded power.
module motor_cmd_sequencer
  import motor_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 50000,
  parameter int DEAD_CYC   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  motor_cmd_sequencer_if.slave cmd,
  input  logic                 halt,
  output logic                 pwm_l,
  output logic                 pwm_r,
  output logic                 dir_l,
  output logic                 dir_r,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PRE_W  = $clog2(TICK_DIV + 1);
  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYC - 1);

  drive_cmd_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  state_e             state_q, state_d;
  drive_cmd_t         cur_q, cur_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [7:0]         rem_q, rem_d;
  logic [DEAD_W-1:0]  dead_q, dead_d;
  logic [1:0]         dir_q, dir_d;
  logic               done_q, done_d, aborted_q, aborted_d;
  logic [6:0]         pwr_q, pwr_d;
  drive_cmd_t         wr_cmd;
  logic               full, empty, push, pop, run_en;
  logic [6:0]         pwr_tgt;

  // ready comes from the registered count only; halt refuses pushes
  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  assign cmd.cmd_ready = !full && !halt;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pwr_tgt       = (cur_q.op == OP_STOP) ? 7'd0 : cur_q.power;

  // pack the incoming bytes; unused upper bits are dropped here
  always_comb begin
    wr_cmd            = '0;
    wr_cmd.op         = op_e'(cmd.cmd1[1:0]);
    wr_cmd.spin_right = cmd.cmd1[2];
    wr_cmd.power      = cmd.cmd2[6:0];
    wr_cmd.dur        = cmd.cmd3;
  end

  // FIFO pointer/count update; halt flushes by snapping read to write
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (halt) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // FIFO storage is data only and needs no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_cmd;
  end

  // sequencer next-state: IDLE -> LOAD -> RUN -> DEAD -> IDLE
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    presc_d   = presc_q;
    rem_d     = rem_q;
    dead_d    = dead_q;
    dir_d     = dir_q;
    pwr_d     = pwr_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !halt) begin
          pop     = 1'b1;
          cur_d   = mem_q[rd_ptr_q];
          dir_d   = drive_dir(mem_q[rd_ptr_q]);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        presc_d = '0;
        rem_d   = cur_q.dur;
`ifdef MOTOR_RAMP_EN
        pwr_d   = '0;
`else
        pwr_d   = pwr_tgt;
`endif
        dead_d  = '0;
        if (halt) begin
          aborted_d = 1'b1;
          state_d   = S_DEAD;
        end else if (cur_q.dur == 8'd0) begin
          done_d  = 1'b1;
          state_d = S_DEAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        dead_d = '0;
        if (halt) begin
          aborted_d = 1'b1;
          state_d   = S_DEAD;
        end else if (presc_q == PRE_MAX) begin
          presc_d = '0;
          rem_d   = rem_q - 8'd1;
`ifdef MOTOR_RAMP_EN
          if (pwr_q < pwr_tgt) pwr_d = pwr_q + 7'd1;
`endif
          if (rem_q == 8'd1) begin
            done_d  = 1'b1;
            state_d = S_DEAD;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_DEAD: begin
        if (dead_q == DEAD_MAX) state_d = S_IDLE;
        else                    dead_d  = dead_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control registers; cur_q is payload and is not reset
  always_ff @(posedge clk) begin
    cur_q <= cur_d;
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      rem_q     <= '0;
      dead_q    <= '0;
      dir_q     <= '0;
      pwr_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      rem_q     <= rem_d;
      dead_q    <= dead_d;
      dir_q     <= dir_d;
      pwr_q     <= pwr_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign run_en = (state_q == S_RUN);

  motor_pwm_gen u_pwm (
    .clk     (clk),
    .reset   (reset),
    .en      (run_en),
    .power_l (pwr_q),
    .power_r (pwr_q),
    .pwm_l   (pwm_l),
    .pwm_r   (pwm_r)
  );

  assign dir_l   = dir_q[1];
  assign dir_r   = dir_q[0];
  assign busy    = (state_q != S_IDLE) || !empty;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Scoreboard bench for motor_cmd_sequencer (TICK_DIV=4, DEAD_CYC=2, FIFO_DEPTH=4).
module tb_motor_cmd_sequencer;
  localparam int TICK  = 4;
  localparam int DEAD  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt = 1'b0;
  logic pwm_l, pwm_r, dir_l, dir_r, busy, done, aborted;

  motor_cmd_sequencer_if bus();

  motor_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TICK_DIV(TICK), .DEAD_CYC(DEAD)) dut (
    .clk(clk), .reset(reset), .cmd(bus), .halt(halt),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // cycle index since reset; also equals the free-running PWM counter phase
  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // expected completion record: kind 0 = done, 1 = aborted
  typedef struct {
    int         kind;
    int         load;
    int         endc;
    logic [1:0] dir;
    int         p;
  } exp_t;

  exp_t sb[$];
  int   pend_pop[$];
  int   last_end = -1000;

  // expected number of PWM-high cycles in the RUN window [load+1, endc-1]
  function automatic int exp_high(int load, int endc, int p);
    int n = 0;
    int pe;
    int k;
    for (int t = load + 1; t < endc; t++) begin
      pe = p;
      k  = (t - load - 1) / TICK;
`ifdef MOTOR_RAMP_EN
      pe = (k < p) ? k : p;
`endif
      if ((t % 128) < pe) n++;
    end
    return n;
  endfunction

  task automatic model_push(int c, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3);
    exp_t e;
    int   rdy;
    rdy = (c + 1 > last_end + DEAD) ? c + 1 : last_end + DEAD;
    e.kind = 0;
    e.load = rdy + 1;
    e.endc = rdy + 2 + int'(c3) * TICK;
    case (c1[1:0])
      2'd2:    e.dir = 2'b00;
      2'd3:    e.dir = c1[2] ? 2'b10 : 2'b01;
      default: e.dir = 2'b11;
    endcase
    e.p = (c1[1:0] == 2'd0) ? 0 : int'(c2[6:0]);
    sb.push_back(e);
    pend_pop.push_back(rdy);
    last_end = e.endc;
  endtask

  task automatic model_halt(int c);
    exp_t keep[$];
    exp_t e;
    int   le = -1000;
    pend_pop.delete();
    foreach (sb[i]) begin
      e = sb[i];
      if (e.endc <= c) keep.push_back(e);
      else if (e.load <= c) begin
        e.kind = 1;
        e.endc = c + 1;
        keep.push_back(e);
      end
    end
    sb = keep;
    foreach (sb[i]) if (sb[i].endc > le) le = sb[i].endc;
    last_end = le;
  endtask

  // one stimulus cycle: drive after the edge, update the model, check ready
  task automatic cycle(logic v, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3, logic h);
    int   c;
    logic exp_ready;
    @(posedge clk);
    #1;
    bus.cmd_valid = v;
    bus.cmd1 = c1;
    bus.cmd2 = c2;
    bus.cmd3 = c3;
    halt = h;
    c = cyc;
    while (pend_pop.size() != 0 && pend_pop[0] < c) void'(pend_pop.pop_front());
    exp_ready = !h && (pend_pop.size() < DEPTH);
    if (h) model_halt(c);
    else if (v && exp_ready) model_push(c, c1, c2, c3);
    @(negedge clk);
    check("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    halt = 1'b0;
    bus.cmd_valid = 1'b0;
    sb.delete();
    pend_pop.delete();
    last_end = -1000;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outputs",
          32'({pwm_l, pwm_r, dir_l, dir_r, busy, done, aborted, bus.cmd_ready}),
          32'(8'b0000_0001));
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 600) begin
      idle(1);
      k++;
    end
    check("drain_complete", 32'(sb.size()), 32'd0);
    sb.delete();
    idle(DEAD + 2);
    check("busy_after_drain", 32'(busy), 32'd0);
  endtask

  // monitor: accumulate PWM-high cycles, compare at each done/aborted pulse
  int   hl = 0;
  int   hr = 0;
  exp_t me;
  always @(negedge clk) begin
    if (reset) begin
      hl = 0;
      hr = 0;
    end else begin
      hl += int'(pwm_l);
      hr += int'(pwm_r);
      if (done || aborted) begin
        check("done_aborted_exclusive", 32'(done && aborted), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          me = sb.pop_front();
          check("event_kind", 32'(aborted), 32'(me.kind));
          check("event_cycle", 32'(cyc), 32'(me.endc));
          check("event_dir", 32'({dir_l, dir_r}), 32'(me.dir));
          check("pwm_l_high_cycles", 32'(hl), 32'(exp_high(me.load, me.endc, me.p)));
          check("pwm_r_high_cycles", 32'(hr), 32'(exp_high(me.load, me.endc, me.p)));
        end
        hl = 0;
        hr = 0;
      end else if (sb.size() != 0 && cyc > sb[0].endc) begin
        check("missing_event", 32'(cyc), 32'(sb[0].endc));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd1 = '0;
    bus.cmd2 = '0;
    bus.cmd3 = '0;
    do_reset(3);

    // FWD p=64 d=3
    cycle(1'b1, 8'd1, 8'd64, 8'd3, 1'b0);
    idle(1);
    check("busy_after_push", 32'(busy), 32'd1);
    drain();

    // back-to-back pushes until the queue fills and refuses
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'd1, 8'(20 * i + 5), 8'd4, 1'b0);
    drain();

    // SPIN right p=127 d=1, then REV p=10 d=0
    cycle(1'b1, 8'd7, 8'd127, 8'd1, 1'b0);
    cycle(1'b1, 8'd2, 8'd10, 8'd0, 1'b0);
    drain();

    // STOP with nonzero power must not drive PWM; ignored bits set
    cycle(1'b1, 8'hF8, 8'hFF, 8'd2, 1'b0);
    drain();

    // halt mid-RUN with two commands queued
    cycle(1'b1, 8'd1, 8'd100, 8'd5, 1'b0);
    cycle(1'b1, 8'd2, 8'd50, 8'd2, 1'b0);
    cycle(1'b1, 8'd3, 8'd60, 8'd2, 1'b0);
    idle(5);
    cycle(1'b1, 8'd1, 8'd9, 8'd1, 1'b1);
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    @(negedge clk);
    check("pwm_off_after_halt", 32'({pwm_l, pwm_r}), 32'd0);
    idle(20);
    drain();

    // reset mid-RUN, then a fresh command
    cycle(1'b1, 8'd1, 8'd120, 8'd5, 1'b0);
    cycle(1'b1, 8'd2, 8'd30, 8'd1, 1'b0);
    idle(6);
    do_reset(1);
    cycle(1'b1, 8'd1, 8'd90, 8'd2, 1'b0);
    drain();

    // randomized traffic with occasional halt bursts
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        repeat ($urandom_range(1, 3))
          cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 3)), 1'b1);
      end else begin
        cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 3)), 1'b0);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
